// File: rtl/spi_slave_if.sv
// SPI mode-3 target front end: oversamples cs/sclk/mosi in the sys_clk domain,
// deframes MOSI into an rx byte stream and serialises a tx byte stream onto MISO.
module spi_slave_if #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] TX_IDLE     = 8'hFF
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       spi_clk_i,
    input  logic       spi_cs_i,
    input  logic       spi_mosi_i,
    output logic       spi_miso_o,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       rx_overflow,
    output logic       tx_underrun,
    output logic       frame_err,
    input  logic       clr_status
);

    // Each stage carries {sclk, cs, mosi}; idle pins are sclk high, cs high.
    localparam logic [2:0] SYNC_RST = 3'b110;

    logic [SYNC_STAGES-1:0][2:0] sync_reg;
    logic       clk_dly_reg;
    logic       cs_dly_reg;
    logic [2:0] bit_cnt_reg;
    logic [7:0] rx_shreg_reg;
    logic [7:0] tx_shreg_reg;
    logic       byte_done_reg;
    logic       miso_reg;
    logic [7:0] rx_data_reg;
    logic       rx_valid_reg;
    logic       busy_reg;
    logic       rx_overflow_reg;
    logic       tx_underrun_reg;
    logic       frame_err_reg;

    logic       sclk_s;
    logic       cs_s;
    logic       mosi_s;
    logic       active;
    logic       sclk_rise;
    logic       sclk_fall;
    logic       cs_rise;
    logic       cs_fall;
    logic       tx_load;
    logic [7:0] tx_next;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_reg <= {SYNC_STAGES{SYNC_RST}};
        end else begin
            sync_reg[0] <= {spi_clk_i, spi_cs_i, spi_mosi_i};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= sync_reg[i-1];
            end
        end
    end

    assign sclk_s = sync_reg[SYNC_STAGES-1][2];
    assign cs_s   = sync_reg[SYNC_STAGES-1][1];
    assign mosi_s = sync_reg[SYNC_STAGES-1][0];

    // sclk edges count only when cs was low both before and now, so an sclk
    // edge coinciding with either cs edge is dropped.
    assign active    = ~cs_s & ~cs_dly_reg;
    assign sclk_rise = active &  sclk_s & ~clk_dly_reg;
    assign sclk_fall = active & ~sclk_s &  clk_dly_reg;
    assign cs_rise   =  cs_s & ~cs_dly_reg;
    assign cs_fall   = ~cs_s &  cs_dly_reg;

    assign tx_load  = sclk_fall && (bit_cnt_reg == 3'd0);
    assign tx_next  = tx_valid ? tx_data : TX_IDLE;
    assign tx_ready = tx_load & tx_valid;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            clk_dly_reg     <= 1'b1;
            cs_dly_reg      <= 1'b1;
            bit_cnt_reg     <= 3'd0;
            rx_shreg_reg    <= 8'h00;
            tx_shreg_reg    <= 8'h00;
            byte_done_reg   <= 1'b0;
            miso_reg        <= 1'b1;
            rx_data_reg     <= 8'h00;
            rx_valid_reg    <= 1'b0;
            busy_reg        <= 1'b0;
            rx_overflow_reg <= 1'b0;
            tx_underrun_reg <= 1'b0;
            frame_err_reg   <= 1'b0;
        end else begin
            clk_dly_reg   <= sclk_s;
            cs_dly_reg    <= cs_s;
            byte_done_reg <= sclk_rise && (bit_cnt_reg == 3'd7);

            // Clear first so a same-cycle set below takes precedence.
            if (clr_status) begin
                rx_overflow_reg <= 1'b0;
                tx_underrun_reg <= 1'b0;
                frame_err_reg   <= 1'b0;
            end

            if (cs_rise) begin
                busy_reg    <= 1'b0;
                bit_cnt_reg <= 3'd0;
                if (bit_cnt_reg != 3'd0) begin
                    frame_err_reg <= 1'b1;
                end
            end else if (cs_fall) begin
                busy_reg <= 1'b1;
            end

            if (cs_s) begin
                miso_reg <= 1'b1;
            end

            if (sclk_rise) begin
                rx_shreg_reg <= {rx_shreg_reg[6:0], mosi_s};
                bit_cnt_reg  <= bit_cnt_reg + 3'd1;
            end

            if (sclk_fall) begin
                if (tx_load) begin
                    tx_shreg_reg <= tx_next;
                    miso_reg     <= tx_next[7];
                    if (!tx_valid) begin
                        tx_underrun_reg <= 1'b1;
                    end
                end else begin
                    tx_shreg_reg <= {tx_shreg_reg[6:0], 1'b0};
                    miso_reg     <= tx_shreg_reg[6];
                end
            end

            // Hand-off runs one cycle after the completing rise; rx_shreg cannot
            // move again before then because sclk is at most sys_clk/4.
            if (byte_done_reg) begin
                if (!rx_valid_reg || rx_ready) begin
                    rx_data_reg  <= rx_shreg_reg;
                    rx_valid_reg <= 1'b1;
                end else begin
                    rx_overflow_reg <= 1'b1;
                end
            end else if (rx_valid_reg && rx_ready) begin
                rx_valid_reg <= 1'b0;
            end
        end
    end

    assign spi_miso_o  = miso_reg;
    assign rx_data     = rx_data_reg;
    assign rx_valid    = rx_valid_reg;
    assign busy        = busy_reg;
    assign rx_overflow = rx_overflow_reg;
    assign tx_underrun = tx_underrun_reg;
    assign frame_err   = frame_err_reg;

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: a bit-banged mode-3 master on the raw pins,
// with a monitor logging rx handshakes and tx_ready pulses.
module tb_spi_slave_if;

    localparam int SYNC = 2;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic       spi_clk;
    logic       spi_cs;
    logic       spi_mosi;
    logic       spi_miso;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       rx_overflow;
    logic       tx_underrun;
    logic       frame_err;
    logic       clr_status;

    int checks = 0;
    int errors = 0;
    int tx_pulses = 0;
    int rx_valid_cycles = 0;
    logic [7:0] rx_q[$];

    spi_slave_if #(.SYNC_STAGES(SYNC), .TX_IDLE(8'hFF)) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .spi_clk_i   (spi_clk),
        .spi_cs_i    (spi_cs),
        .spi_mosi_i  (spi_mosi),
        .spi_miso_o  (spi_miso),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .rx_overflow (rx_overflow),
        .tx_underrun (tx_underrun),
        .frame_err   (frame_err),
        .clr_status  (clr_status)
    );

    always #5 sys_clk = ~sys_clk;

    // Inputs change on the falling edge; look 1 unit later, well clear of posedge.
    always @(negedge sys_clk) begin
        #1;
        if (tx_ready) tx_pulses++;
        if (rx_valid) rx_valid_cycles++;
        if (rx_valid && rx_ready) rx_q.push_back(rx_data);
    end

    initial begin
        #10_000_000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp);
        logic [7:0] got;
        got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
        chk(tag, {24'h0, got}, {24'h0, exp});
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic spi_bits(input logic [7:0] mo, input int nbits, input int half,
                            output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_clk  = 1'b0;
            spi_mosi = mo[i];
            wait_cyc(half);
            mi[i]   = spi_miso;
            spi_clk = 1'b1;
            wait_cyc(half);
        end
    endtask

    task automatic spi_byte(input logic [7:0] mo, input int half, output logic [7:0] mi);
        spi_bits(mo, 8, half, mi);
        $display("xfer mosi=%02h miso=%02h", mo, mi);
    endtask

    task automatic cs_low();
        spi_cs = 1'b0;
        wait_cyc(4);
    endtask

    task automatic cs_high();
        wait_cyc(4);
        spi_cs = 1'b1;
        wait_cyc(8);
    endtask

    initial begin
        logic [7:0] m1;
        logic [7:0] m2;
        int lat;
        logic got;

        sys_rst_n = 1'b0; spi_clk = 1'b1; spi_cs = 1'b1; spi_mosi = 1'b0;
        rx_ready = 1'b0; tx_data = 8'h00; tx_valid = 1'b0; clr_status = 1'b0;
        wait_cyc(3);
        chk("rst_miso", {31'h0, spi_miso}, 32'h1);
        chk("rst_rx_valid", {31'h0, rx_valid}, 32'h0);
        chk("rst_rx_data", {24'h0, rx_data}, 32'h0);
        chk("rst_tx_ready", {31'h0, tx_ready}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_flags", {29'h0, rx_overflow, tx_underrun, frame_err}, 32'h0);
        sys_rst_n = 1'b1;
        wait_cyc(4);

        // Reset asserted after 3 bits of a frame takes effect immediately.
        cs_low();
        spi_bits(8'hE0, 3, 8, m1);
        sys_rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'h0, busy}, 32'h0);
        chk("midrst_miso", {31'h0, spi_miso}, 32'h1);
        chk("midrst_flags", {29'h0, rx_overflow, tx_underrun, frame_err}, 32'h0);
        spi_clk = 1'b1; spi_cs = 1'b1;
        wait_cyc(3);
        sys_rst_n = 1'b1;
        wait_cyc(4);

        // Full-duplex byte: 0xA5 in, 0x3C out.
        rx_ready = 1'b1; tx_valid = 1'b1; tx_data = 8'h3C;
        tx_pulses = 0; rx_valid_cycles = 0; rx_q.delete();
        cs_low();
        chk("busy_active", {31'h0, busy}, 32'h1);
        spi_byte(8'hA5, 8, m1);
        cs_high();
        chk("a5_miso", {24'h0, m1}, 32'h3C);
        chk("a5_rx_count", rx_q.size(), 32'd1);
        pop_chk("a5_rx_byte", 8'hA5);
        chk("a5_valid_cycles", rx_valid_cycles, 32'd1);
        chk("a5_tx_pulses", tx_pulses, 32'd1);
        chk("a5_busy_idle", {31'h0, busy}, 32'h0);
        chk("a5_frame_err", {31'h0, frame_err}, 32'h0);

        // Three bytes with nobody consuming: first is held, the rest overflow.
        rx_ready = 1'b0; tx_data = 8'h00;
        tx_pulses = 0;
        cs_low();
        spi_byte(8'h01, 8, m1);
        spi_byte(8'h02, 8, m1);
        spi_byte(8'h03, 8, m1);
        cs_high();
        chk("ovf_rx_valid", {31'h0, rx_valid}, 32'h1);
        chk("ovf_rx_data", {24'h0, rx_data}, 32'h01);
        chk("ovf_flag", {31'h0, rx_overflow}, 32'h1);
        chk("ovf_tx_pulses", tx_pulses, 32'd3);
        rx_ready = 1'b1;
        wait_cyc(2);
        chk("ovf_drain_count", rx_q.size(), 32'd1);
        pop_chk("ovf_drain_byte", 8'h01);
        chk("ovf_drain_valid", {31'h0, rx_valid}, 32'h0);

        // No tx data: master sees TX_IDLE.
        tx_valid = 1'b0; tx_pulses = 0;
        cs_low();
        spi_byte(8'h11, 8, m1);
        spi_byte(8'h22, 8, m2);
        cs_high();
        chk("udr_miso0", {24'h0, m1}, 32'hFF);
        chk("udr_miso1", {24'h0, m2}, 32'hFF);
        chk("udr_flag", {31'h0, tx_underrun}, 32'h1);
        chk("udr_tx_pulses", tx_pulses, 32'd0);
        pop_chk("udr_rx0", 8'h11);
        pop_chk("udr_rx1", 8'h22);
        clr_status = 1'b1;
        wait_cyc(1);
        clr_status = 1'b0;
        wait_cyc(1);
        chk("clr_underrun", {31'h0, tx_underrun}, 32'h0);
        chk("clr_overflow", {31'h0, rx_overflow}, 32'h0);

        // cs released after 5 bits.
        tx_valid = 1'b1; tx_data = 8'h00; rx_q.delete();
        cs_low();
        spi_bits(8'hC3, 5, 8, m1);
        cs_high();
        chk("part_rx_count", rx_q.size(), 32'd0);
        chk("part_rx_valid", {31'h0, rx_valid}, 32'h0);
        chk("part_frame_err", {31'h0, frame_err}, 32'h1);
        chk("part_busy", {31'h0, busy}, 32'h0);
        cs_low();
        spi_byte(8'h5A, 8, m1);
        cs_high();
        chk("after_part_count", rx_q.size(), 32'd1);
        pop_chk("after_part_byte", 8'h5A);

        // Back-to-back bytes at sclk = sys_clk/4.
        rx_valid_cycles = 0; rx_q.delete();
        cs_low();
        spi_byte(8'hDE, 2, m1);
        spi_byte(8'hAD, 2, m1);
        spi_byte(8'hBE, 2, m1);
        spi_byte(8'hEF, 2, m1);
        cs_high();
        chk("b2b_count", rx_q.size(), 32'd4);
        pop_chk("b2b_0", 8'hDE);
        pop_chk("b2b_1", 8'hAD);
        pop_chk("b2b_2", 8'hBE);
        pop_chk("b2b_3", 8'hEF);
        chk("b2b_valid_cycles", rx_valid_cycles, 32'd4);
        chk("b2b_overflow", {31'h0, rx_overflow}, 32'h0);

        // Latency from the sampling edge of the 8th raw rise to rx_valid.
        rx_q.delete();
        cs_low();
        spi_bits(8'h96, 7, 2, m1);
        spi_clk = 1'b0; spi_mosi = 1'b0;
        wait_cyc(2);
        spi_clk = 1'b1;
        @(posedge sys_clk);
        lat = 0; got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(posedge sys_clk);
            #1;
            lat++;
            if (rx_valid) got = 1'b1;
        end
        chk("lat_seen", {31'h0, got}, 32'h1);
        chk("lat_cycles", lat, SYNC + 1);
        cs_high();
        pop_chk("lat_byte", 8'h96);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave_if.md
Name: spi_slave_if

Overview:
- SPI target (slave) front end that consumes the cs/sclk/mosi pins driven by the DPI SPI bridge and returns miso to it.
- Oversamples the SPI pins in the sys_clk domain and deframes MOSI into bytes on a valid/ready stream.
- Serialises bytes from a tx valid/ready stream onto MISO.
- Fixed SPI mode 3: idle sclk high, data driven on sclk fall, sampled on sclk rise, MSB first, cs active-low.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on spi_clk_i, spi_cs_i and spi_mosi_i (legal range 2..4).
- TX_IDLE, 8'hFF, byte shifted out when no tx byte is available at a byte boundary.

Ports:
- sys_clk  input  1  system clock; must run at least 4x the SPI sclk frequency.
- sys_rst_n  input  1  asynchronous active-low reset.
- spi_clk_i  input  1  SPI clock from master.
- spi_cs_i  input  1  SPI chip select from master, active-low.
- spi_mosi_i  input  1  SPI data from master.
- spi_miso_o  output  1  SPI data to master.
- rx_data  output  8  received byte.
- rx_valid  output  1  rx_data holds an unconsumed byte.
- rx_ready  input  1  consumer accepts rx_data.
- tx_data  input  8  next byte to transmit.
- tx_valid  input  1  tx_data is available.
- tx_ready  output  1  one-cycle pulse: tx_data taken this cycle.
- busy  output  1  synchronised cs is active (low).
- rx_overflow  output  1  sticky: a received byte was dropped.
- tx_underrun  output  1  sticky: TX_IDLE was substituted for a missing tx byte.
- frame_err  output  1  sticky: cs deasserted with a partial byte.
- clr_status  input  1  clears all three sticky flags.

Behaviour:
- Reset (async, sys_rst_n low):
  - Sync chains: clk=1, cs=1, mosi=0.
  - bit_cnt=0, shift registers=0.
  - Outputs: spi_miso_o=1, rx_data=0, rx_valid=0, tx_ready=0, busy=0, all sticky flags=0.
- Synchronisation and edge detect:
  - A rise or fall is detected by comparing the last sync stage with a delay flop.
  - Edges are ignored while synchronised cs is high.
  - Edge processing occurs in the cycle the delay flop differs.
- Receive (each rise while cs low):
  - rx_shreg = {rx_shreg[6:0], mosi_sync}; bit_cnt increments (3-bit, wraps 7 to 0).
  - On the rise that completes bit 7, the byte is complete.
  - If rx_valid=0, or rx_valid&&rx_ready in the same cycle: load rx_data with the completed byte; rx_valid=1 next cycle.
  - Otherwise: drop the new byte; keep the old rx_data; set rx_overflow.
  - rx_valid clears on rx_valid&&rx_ready when no new byte lands in that cycle.
- Transmit (each fall while cs low):
  - If bit_cnt==0 (byte boundary):
    - If tx_valid=1: tx_shreg=tx_data and tx_ready pulses high in that same cycle.
    - If tx_valid=0: tx_shreg=TX_IDLE and tx_underrun is set.
    - spi_miso_o = loaded byte bit 7.
  - Else: tx_shreg shifts left; spi_miso_o = new bit 7.
  - spi_miso_o holds its value between falls. It is driven 1 while cs is high; there is no tristate.
- Latency: rx_valid rises SYNC_STAGES+1 sys_clk cycles after the sys_clk edge that first samples the 8th raw sclk rise.
- cs rise (synchronised):
  - busy=0 and bit_cnt=0.
  - If bit_cnt!=0, the partial rx byte is discarded and frame_err is set; a pending rx byte is kept.
  - The tx byte in flight is discarded, not re-sent.
- cs fall: busy=1; no tx load until the first sclk fall.
- clr_status in the same cycle as a flag-setting event: the set wins.
- A sclk edge coincident with a cs edge in the same sync cycle:
  - cs rise processed first, so the sclk edge is ignored.
  - On cs fall, the sclk edge is ignored.

Test Plan:
- Reset mid-transfer (assert sys_rst_n=0 after 3 bits) -> all outputs at reset values immediately; the next full frame receives correctly.
- cs low, master sends 0xA5 with rx_ready=1 and tx_valid=1, tx_data=0x3C -> rx_data=0xA5 with rx_valid for 1 cycle; MISO bits sampled by master = 0x3C; single tx_ready pulse.
- Three-byte frame 0x01,0x02,0x03 with rx_ready=0 throughout -> rx_data=0x01 held, rx_valid=1, rx_overflow=1; then rx_ready=1 -> 0x01 consumed, rx_valid=0.
- tx_valid=0 for a 2-byte frame -> master reads 0xFF,0xFF; tx_underrun=1; clr_status -> flag cleared.
- cs deasserted after 5 bits -> no rx_valid, frame_err=1, busy=0; next frame byte 0x5A received intact.
- Back-to-back bytes with rx_ready tied high at sclk = sys_clk/4 -> every byte delivered, no overflow, latency SYNC_STAGES+1 cycles.
